// File: rtl/split_eval_pkg.sv
// Shared types for the split_eval constraint evaluator: operator codes, FSM states and the
// default-width constraint entry.
package split_eval_pkg;

   localparam int unsigned CONS_VAR_W  = 8;
   localparam int unsigned CONS_VIDX_W = 6;

   typedef enum logic [2:0] {
      OP_AND    = 3'd0,
      OP_OR     = 3'd1,
      OP_XOR    = 3'd2,
      OP_SUB    = 3'd3,
      OP_NE     = 3'd4,
      OP_NZMASK = 3'd5,
      OP_SHR    = 3'd6,
      OP_TRUE   = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_EVAL,
      S_DONE
   } state_e;

   typedef struct packed {
      logic                   en;
      op_e                    op;
      logic [CONS_VIDX_W-1:0] a;
      logic [CONS_VIDX_W-1:0] b;
      logic [CONS_VAR_W-1:0]  k;
   } cons_entry_t;

   function automatic int unsigned ceil_div(input int unsigned n, input int unsigned d);
      return (n + d - 1) / d;
   endfunction

endpackage

// File: rtl/split_eval_lane.sv
// Combinational evaluation of one constraint entry against the captured candidate.
// Operand indices past the last variable read as zero.
module split_eval_lane
   import split_eval_pkg::*;
#(
   parameter int unsigned NUM_VARS = 50,
   parameter int unsigned VAR_W    = 8,
   parameter int unsigned VIDX_W   = 6
) (
   input  logic [NUM_VARS*VAR_W-1:0] vars,
   input  op_e                       op,
   input  logic [VIDX_W-1:0]         a_idx,
   input  logic [VIDX_W-1:0]         b_idx,
   input  logic [VAR_W-1:0]          k,
   output logic                      pass
);

   logic [VAR_W-1:0] a;
   logic [VAR_W-1:0] b;
   logic [VAR_W-1:0] diff;

   always_comb begin
      a = '0;
      b = '0;
      if ({1'b0, a_idx} < NUM_VARS[VIDX_W:0]) a = vars[a_idx*VAR_W +: VAR_W];
      if ({1'b0, b_idx} < NUM_VARS[VIDX_W:0]) b = vars[b_idx*VAR_W +: VAR_W];
      diff = a - b;
   end

   always_comb begin
      pass = 1'b1;
      unique case (op)
         OP_AND:    pass = |((a & b) ^ k);
         OP_OR:     pass = |((a | b) ^ k);
         OP_XOR:    pass = |(a ^ b ^ k);
         OP_SUB:    pass = |(diff ^ k);
         OP_NE:     pass = (a != b);
         OP_NZMASK: pass = !(|(a & k));
         OP_SHR:    pass = |(a >> k[2:0]);
         OP_TRUE:   pass = 1'b1;
      endcase
   end

endmodule

// File: rtl/split_eval_seq.sv
// Sequential constraint-conjunction evaluator: LANES table entries checked per cycle.
// Define SPLIT_EVAL_FAIL_MASK_EN to add out_fail_mask and disable early exit.
module split_eval_seq
   import split_eval_pkg::*;
#(
   parameter int unsigned NUM_VARS = 50,
   parameter int unsigned VAR_W    = 8,
   parameter int unsigned NUM_CONS = 32,
   parameter int unsigned LANES    = 4,
   parameter int unsigned CNT_W    = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          cfg_we,
   input  logic [$clog2(NUM_CONS)-1:0]   cfg_addr,
   input  logic                          cfg_en,
   input  logic [2:0]                    cfg_op,
   input  logic [$clog2(NUM_VARS)-1:0]   cfg_a,
   input  logic [$clog2(NUM_VARS)-1:0]   cfg_b,
   input  logic [VAR_W-1:0]              cfg_k,
   output logic                          cfg_err,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [NUM_VARS*VAR_W-1:0]     in_vars,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic                          out_sat,
   output logic [$clog2(NUM_CONS)-1:0]   out_fail_idx,
   output logic [CNT_W-1:0]              sat_count,
   output logic                          busy
`ifdef SPLIT_EVAL_FAIL_MASK_EN
   ,
   output logic [NUM_CONS-1:0]           out_fail_mask
`endif
);

   localparam int unsigned CIDX_W     = $clog2(NUM_CONS);
   localparam int unsigned VIDX_W     = $clog2(NUM_VARS);
   localparam int unsigned NUM_GROUPS = ceil_div(NUM_CONS, LANES);
   localparam int unsigned G_W        = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
   localparam logic [G_W-1:0] LAST_G  = G_W'(NUM_GROUPS - 1);

   state_e                     state_q;
   logic [G_W-1:0]             group_q;
   logic [NUM_VARS*VAR_W-1:0]  vars_q;

   logic [NUM_CONS-1:0]        tbl_en;
   op_e                        tbl_op [NUM_CONS];
   logic [VIDX_W-1:0]          tbl_a  [NUM_CONS];
   logic [VIDX_W-1:0]          tbl_b  [NUM_CONS];
   logic [VAR_W-1:0]           tbl_k  [NUM_CONS];

   logic                       cfg_wr_ok;
   logic [LANES-1:0]           lane_fail;
   logic [CIDX_W-1:0]          lane_idx [LANES];

   assign in_ready  = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign cfg_wr_ok = cfg_we && (state_q == S_IDLE) && ({1'b0, cfg_addr} < NUM_CONS[CIDX_W:0]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tbl_en <= '0;
         for (int i = 0; i < int'(NUM_CONS); i++) begin
            tbl_op[i] <= OP_TRUE;
            tbl_a[i]  <= '0;
            tbl_b[i]  <= '0;
            tbl_k[i]  <= '0;
         end
      end else if (cfg_wr_ok) begin
         tbl_en[cfg_addr] <= cfg_en;
         tbl_op[cfg_addr] <= op_e'(cfg_op);
         tbl_a[cfg_addr]  <= cfg_a;
         tbl_b[cfg_addr]  <= cfg_b;
         tbl_k[cfg_addr]  <= cfg_k;
      end
   end

   for (genvar l = 0; l < int'(LANES); l++) begin : g_lane
      logic [31:0]       idx_full;
      logic              in_range;
      logic              pass;

      assign idx_full    = 32'(group_q) * LANES + 32'(l);
      assign in_range    = idx_full < NUM_CONS;
      // Out-of-range lanes read entry 0 but are forced true below.
      assign lane_idx[l] = in_range ? idx_full[CIDX_W-1:0] : '0;

      split_eval_lane #(
         .NUM_VARS (NUM_VARS),
         .VAR_W    (VAR_W),
         .VIDX_W   (VIDX_W)
      ) u_lane (
         .vars  (vars_q),
         .op    (tbl_op[lane_idx[l]]),
         .a_idx (tbl_a[lane_idx[l]]),
         .b_idx (tbl_b[lane_idx[l]]),
         .k     (tbl_k[lane_idx[l]]),
         .pass  (pass)
      );

      assign lane_fail[l] = in_range && tbl_en[lane_idx[l]] && !pass;
   end

`ifdef SPLIT_EVAL_FAIL_MASK_EN
   logic [NUM_CONS-1:0] mask_q;
   logic [NUM_CONS-1:0] mask_next;

   function automatic logic [CIDX_W-1:0] lowest_set(input logic [NUM_CONS-1:0] m);
      logic [CIDX_W-1:0] r;
      r = '0;
      for (int i = int'(NUM_CONS) - 1; i >= 0; i--) begin
         if (m[i]) r = CIDX_W'(i);
      end
      return r;
   endfunction

   always_comb begin
      mask_next = mask_q;
      for (int l = 0; l < int'(LANES); l++) begin
         if (lane_fail[l]) mask_next[lane_idx[l]] = 1'b1;
      end
   end

   assign out_fail_mask = mask_q;
`else
   logic              any_fail;
   logic [CIDX_W-1:0] first_idx;

   // Lanes are in ascending index order, so the lowest failing lane wins.
   always_comb begin
      any_fail  = |lane_fail;
      first_idx = '0;
      for (int l = int'(LANES) - 1; l >= 0; l--) begin
         if (lane_fail[l]) first_idx = lane_idx[l];
      end
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         group_q      <= '0;
         vars_q       <= '0;
         out_valid    <= 1'b0;
         out_sat      <= 1'b0;
         out_fail_idx <= '0;
         sat_count    <= '0;
         cfg_err      <= 1'b0;
`ifdef SPLIT_EVAL_FAIL_MASK_EN
         mask_q       <= '0;
`endif
      end else begin
         cfg_err <= cfg_we && !cfg_wr_ok;
         unique case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  vars_q  <= in_vars;
                  group_q <= '0;
                  state_q <= S_EVAL;
`ifdef SPLIT_EVAL_FAIL_MASK_EN
                  mask_q  <= '0;
`endif
               end
            end
            S_EVAL: begin
`ifdef SPLIT_EVAL_FAIL_MASK_EN
               mask_q <= mask_next;
               if (group_q == LAST_G) begin
                  out_sat      <= ~|mask_next;
                  out_fail_idx <= lowest_set(mask_next);
                  out_valid    <= 1'b1;
                  state_q      <= S_DONE;
               end else begin
                  group_q <= group_q + G_W'(1);
               end
`else
               if (any_fail) begin
                  out_sat      <= 1'b0;
                  out_fail_idx <= first_idx;
                  out_valid    <= 1'b1;
                  state_q      <= S_DONE;
               end else if (group_q == LAST_G) begin
                  out_sat      <= 1'b1;
                  out_fail_idx <= '0;
                  out_valid    <= 1'b1;
                  state_q      <= S_DONE;
               end else begin
                  group_q <= group_q + G_W'(1);
               end
`endif
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (out_sat && !(&sat_count)) sat_count <= sat_count + CNT_W'(1);
                  state_q   <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_split_eval_seq.sv
// Self-checking bench for split_eval_seq: directed scenarios plus randomized tables/candidates
// checked against a behavioural model of the constraint rules.
module tb_split_eval_seq;

   localparam int NV = 50;
   localparam int VW = 8;
   localparam int NC = 32;
   localparam int LN = 4;
   localparam int CW = 16;
   localparam int NG = (NC + LN - 1) / LN;

   logic              clk = 1'b0;
   logic              rst;
   logic              cfg_we;
   logic [4:0]        cfg_addr;
   logic              cfg_en;
   logic [2:0]        cfg_op;
   logic [5:0]        cfg_a;
   logic [5:0]        cfg_b;
   logic [7:0]        cfg_k;
   logic              cfg_err;
   logic              in_valid;
   logic              in_ready;
   logic [NV*VW-1:0]  in_vars;
   logic              out_valid;
   logic              out_ready;
   logic              out_sat;
   logic [4:0]        out_fail_idx;
   logic [CW-1:0]     sat_count;
   logic              busy;
`ifdef SPLIT_EVAL_FAIL_MASK_EN
   logic [NC-1:0]     out_fail_mask;
`endif

   split_eval_seq #(
      .NUM_VARS (NV),
      .VAR_W    (VW),
      .NUM_CONS (NC),
      .LANES    (LN),
      .CNT_W    (CW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .cfg_we       (cfg_we),
      .cfg_addr     (cfg_addr),
      .cfg_en       (cfg_en),
      .cfg_op       (cfg_op),
      .cfg_a        (cfg_a),
      .cfg_b        (cfg_b),
      .cfg_k        (cfg_k),
      .cfg_err      (cfg_err),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_vars      (in_vars),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_sat      (out_sat),
      .out_fail_idx (out_fail_idx),
      .sat_count    (sat_count),
      .busy         (busy)
`ifdef SPLIT_EVAL_FAIL_MASK_EN
      ,
      .out_fail_mask (out_fail_mask)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state
   bit m_en [NC];
   int m_op [NC];
   int m_a  [NC];
   int m_b  [NC];
   int m_k  [NC];
   int cand [NV];
   int m_sat_cnt = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int opnd(input int idx);
      return (idx < NV) ? cand[idx] : 0;
   endfunction

   function automatic bit cons_true(input int i);
      int a, b, k;
      a = opnd(m_a[i]);
      b = opnd(m_b[i]);
      k = m_k[i];
      case (m_op[i])
         0: return ((a & b) ^ k) != 0;
         1: return ((a | b) ^ k) != 0;
         2: return (a ^ b ^ k) != 0;
         3: return (((a - b) & 255) ^ k) != 0;
         4: return a != b;
         5: return (a & k) == 0;
         6: return (a >> (k & 7)) != 0;
         default: return 1'b1;
      endcase
   endfunction

   task automatic model_eval(output bit sat, output int first, output logic [31:0] mask,
                             output int lat);
      sat   = 1'b1;
      first = 0;
      mask  = '0;
      for (int i = NC - 1; i >= 0; i--) begin
         if (m_en[i] && !cons_true(i)) begin
            mask[i] = 1'b1;
            first   = i;
            sat     = 1'b0;
         end
      end
`ifdef SPLIT_EVAL_FAIL_MASK_EN
      lat = NG + 1;
`else
      lat = sat ? NG + 1 : first / LN + 2;
`endif
   endtask

   task automatic pack_cand();
      for (int i = 0; i < NV; i++) in_vars[i*VW +: VW] = 8'(cand[i]);
   endtask

   task automatic set_cfg(input int addr, input bit en, input int op, input int a, input int b,
                          input int k);
      cfg_we   = 1'b1;
      cfg_addr = 5'(addr);
      cfg_en   = en;
      cfg_op   = 3'(op);
      cfg_a    = 6'(a);
      cfg_b    = 6'(b);
      cfg_k    = 8'(k);
   endtask

   // Write while idle; model is updated because the write must land.
   task automatic cfg_write(input int addr, input bit en, input int op, input int a, input int b,
                            input int k);
      set_cfg(addr, en, op, a, b, k);
      m_en[addr] = en; m_op[addr] = op; m_a[addr] = a; m_b[addr] = b; m_k[addr] = k;
      @(posedge clk); #1;
      cfg_we = 1'b0;
   endtask

   task automatic clear_table();
      for (int i = 0; i < NC; i++) cfg_write(i, 1'b0, 7, 0, 0, 0);
   endtask

   task automatic run_cand(input string tag, input int hold, input bit wr_in_hold);
      bit          sat, seen;
      int          first, lat, got;
      logic [31:0] mask;
      model_eval(sat, first, mask, lat);
      pack_cand();
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      cfg_we   = 1'b0;
      check({tag, "_busy"}, 64'(busy), 64'(1));
      got  = 1;
      seen = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
         @(posedge clk); #1;
         got++;
         if (out_valid) seen = 1'b1;
      end
      check({tag, "_seen"}, 64'(seen), 64'(1));
      if (seen) begin
         check({tag, "_lat"}, 64'(got), 64'(lat));
         check({tag, "_sat"}, 64'(out_sat), 64'(sat));
         check({tag, "_idx"}, 64'(out_fail_idx), 64'(first));
`ifdef SPLIT_EVAL_FAIL_MASK_EN
         check({tag, "_mask"}, 64'(out_fail_mask), 64'(mask));
`endif
         check({tag, "_inrdy"}, 64'(in_ready), 64'(0));
         for (int h = 0; h < hold; h++) begin
            // Entry 0 = NE on two zero operands: would fail every candidate if it landed
            if (h == 0 && wr_in_hold) set_cfg(0, 1'b1, 4, 50, 51, 0);
            @(posedge clk); #1;
            cfg_we = 1'b0;
            if (wr_in_hold && h == 0) check({tag, "_cfgerr"}, 64'(cfg_err), 64'(1));
            if (wr_in_hold && h == 1) check({tag, "_cfgerr_end"}, 64'(cfg_err), 64'(0));
            check({tag, "_hold_v"}, 64'(out_valid), 64'(1));
            check({tag, "_hold_sat"}, 64'(out_sat), 64'(sat));
            check({tag, "_hold_idx"}, 64'(out_fail_idx), 64'(first));
            check({tag, "_hold_rdy"}, 64'(in_ready), 64'(0));
         end
         out_ready = 1'b1;
         @(posedge clk); #1;
         out_ready = 1'b0;
         if (sat && m_sat_cnt < 65535) m_sat_cnt++;
         check({tag, "_v_clr"}, 64'(out_valid), 64'(0));
         check({tag, "_idle"}, 64'(in_ready), 64'(1));
         check({tag, "_cnt"}, 64'(sat_count), 64'(m_sat_cnt));
      end
   endtask

   initial begin
      bit rose;
      rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_en = 1'b0; cfg_op = '0; cfg_a = '0;
      cfg_b = '0; cfg_k = '0; in_valid = 1'b0; in_vars = '0; out_ready = 1'b0;
      for (int i = 0; i < NC; i++) begin
         m_en[i] = 1'b0; m_op[i] = 7; m_a[i] = 0; m_b[i] = 0; m_k[i] = 0;
      end
      for (int i = 0; i < NV; i++) cand[i] = 0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_inrdy", 64'(in_ready), 64'(1));
      check("rst_oval", 64'(out_valid), 64'(0));
      check("rst_sat", 64'(out_sat), 64'(0));
      check("rst_idx", 64'(out_fail_idx), 64'(0));
      check("rst_cnt", 64'(sat_count), 64'(0));
      check("rst_cfgerr", 64'(cfg_err), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      rst = 1'b0;
      @(posedge clk); #1;

      run_cand("empty", 0, 1'b0);

      cfg_write(0, 1'b1, 3, 10, 49, 0);
      cand[10] = 8'h3C; cand[49] = 8'h3C;
      run_cand("sub0", 0, 1'b0);

      cfg_write(0, 1'b0, 3, 10, 49, 0);
      cfg_write(29, 1'b1, 2, 1, 36, 0);
      cand[1] = 5; cand[36] = 5;
      run_cand("xor29_fail", 0, 1'b0);
      cand[36] = 6;
      run_cand("xor29_pass", 0, 1'b0);

      run_cand("hold", 5, 1'b1);
      run_cand("after_drop", 0, 1'b0);

      // Write and accept in the same idle cycle: evaluation must see the new entry
      set_cfg(3, 1'b1, 4, 50, 51, 0);
      m_en[3] = 1'b1; m_op[3] = 4; m_a[3] = 50; m_b[3] = 51; m_k[3] = 0;
      run_cand("same_cycle", 0, 1'b0);

      clear_table();
      cfg_write(2, 1'b1, 4, 50, 51, 0);
      cfg_write(17, 1'b1, 4, 50, 51, 0);
      cfg_write(31, 1'b1, 4, 50, 51, 0);
      run_cand("three_fail", 0, 1'b0);

      // Reset during EVAL: result discarded, table cleared
      for (int i = 0; i < NV; i++) cand[i] = 0;
      pack_cand();
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("mid_rst_oval", 64'(out_valid), 64'(0));
      check("mid_rst_inrdy", 64'(in_ready), 64'(1));
      check("mid_rst_busy", 64'(busy), 64'(0));
      check("mid_rst_cnt", 64'(sat_count), 64'(0));
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < NC; i++) m_en[i] = 1'b0;
      m_sat_cnt = 0;
      rose = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         if (out_valid) rose = 1'b1;
      end
      check("mid_rst_noval", 64'(rose), 64'(0));
      run_cand("post_rst", 0, 1'b0);

      for (int it = 0; it < 30; it++) begin
         clear_table();
         for (int e = 0; e < int'($urandom_range(1, 4)); e++) begin
            cfg_write(int'($urandom_range(0, NC - 1)), 1'b1, int'($urandom_range(0, 7)),
                      int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
                      int'($urandom_range(0, 3)));
         end
         for (int i = 0; i < NV; i++) cand[i] = int'($urandom_range(0, 3));
         run_cand("rand", int'($urandom_range(0, 3)), 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/split_eval_seq.md
Name: split_eval_seq

Overview:
- Parametrised, sequential successor to the fixed combinational constraint-conjunction splits.
- Holds a programmable table of NUM_CONS constraints over NUM_VARS packed variables.
- Accepts candidate assignments via valid/ready and evaluates LANES constraints per cycle, with early exit on the first failure.
- Returns SAT/UNSAT, the index of the first failing constraint, and a running SAT count. Sits between the candidate generator and the BDD/solver back end.

Parameters:
- NUM_VARS, 50, number of variables in the candidate vector.
- VAR_W, 8, width of each variable slot; narrower variables are zero-extended.
- NUM_CONS, 32, constraint table depth.
- LANES, 4, constraints evaluated per cycle (1..NUM_CONS).
- CNT_W, 16, width of the SAT counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- cfg_we  in  1  table write strobe
- cfg_addr  in  $clog2(NUM_CONS)  entry index
- cfg_en  in  1  entry enable; disabled entries count as satisfied
- cfg_op  in  3  operator code
- cfg_a  in  $clog2(NUM_VARS)  operand A variable index
- cfg_b  in  $clog2(NUM_VARS)  operand B variable index
- cfg_k  in  VAR_W  constant
- cfg_err  out  1  one-cycle pulse: write dropped because block not IDLE
- in_valid  in  1  candidate valid
- in_ready  out  1  high only in IDLE
- in_vars  in  NUM_VARS*VAR_W  packed candidate; var i at [i*VAR_W +: VAR_W]
- out_valid  out  1  result valid
- out_ready  in  1  result accept
- out_sat  out  1  all enabled constraints true
- out_fail_idx  out  $clog2(NUM_CONS)  lowest failing index; 0 when out_sat
- sat_count  out  CNT_W  number of SAT results accepted
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst=1):
  - FSM goes to IDLE.
  - All table entries become enabled=0.
  - in_ready=1, out_valid=0, out_sat=0, out_fail_idx=0, sat_count=0, cfg_err=0, busy=0.
- Operators. a=var[cfg_a], b=var[cfg_b], k=cfg_k; all ops are VAR_W-bit, mod 2^VAR_W.
  - 0 AND: |((a&b)^k)
  - 1 OR: |((a|b)^k)
  - 2 XOR: |(a^b^k)
  - 3 SUB: |((a-b)^k)
  - 4 NE: a!=b
  - 5 NZMASK: !(|(a&k))
  - 6 SHR: |(a>>k[2:0])
  - 7 TRUE: 1
- FSM IDLE:
  - On in_valid&&in_ready, capture in_vars into an internal register, set group ptr g=0, go to EVAL.
  - in_vars is not used after capture.
- FSM EVAL:
  - Evaluate entries g*LANES .. g*LANES+LANES-1; indices >= NUM_CONS are treated as true.
  - If any enabled lane is false: record the lowest failing index, out_sat=0, go to DONE.
  - Else if this is the last group: out_sat=1, go to DONE.
  - Else g++.
  - Worst-case latency, accept to out_valid: ceil(NUM_CONS/LANES)+1 cycles. First-group failure: 2 cycles.
- FSM DONE:
  - out_valid=1; outputs held stable until out_ready.
  - On out_valid&&out_ready: if out_sat, sat_count++ (saturates at all-ones); return to IDLE.
  - The next candidate can be accepted the cycle after the handshake (no bypass).
- Config:
  - cfg_we in IDLE writes the entry on the clock edge.
  - cfg_we in EVAL/DONE is dropped and cfg_err pulses 1 cycle.
  - cfg_we and in_valid in the same IDLE cycle: the write lands and the candidate is accepted. Evaluation uses the new entry, because the first read is in the next cycle.
- cfg_addr >= NUM_CONS: write dropped, cfg_err pulses.
- cfg_a/cfg_b >= NUM_VARS: operand reads as 0.
- Reset mid-EVAL or mid-DONE: the result is discarded, the table is cleared, and there is no out_valid.
- Table empty or all disabled: out_sat=1 after ceil(NUM_CONS/LANES)+1 cycles.

Optional Feature:
- Macro SPLIT_EVAL_FAIL_MASK_EN.
- Defined:
  - Adds output out_fail_mask [NUM_CONS], one bit per failing enabled constraint.
  - Early exit is disabled; every candidate takes the full ceil(NUM_CONS/LANES)+1 cycles.
  - out_fail_idx stays the lowest set bit of the mask.
- Undefined: the port is absent and early exit applies.

Decomposition:
- Package split_eval_pkg:
  - op_e enum (OP_AND..OP_TRUE, 3 bits).
  - cons_entry_t struct {en, op, a, b, k}, parametrised via localparam widths with VAR_W default 8.
  - State enum {S_IDLE, S_EVAL, S_DONE}.
- Sub-module split_eval_lane: combinational evaluation of one entry against the captured vars. It is instantiated LANES times.

Test Plan:
- Reset, no config, candidate all zeros, out_ready=1 → out_sat=1, out_valid after 9 cycles (32/4+1), sat_count=1.
- Entry 0 = {en,SUB,a=10,b=49,k=0}, candidate var10=var49=0x3C → out_sat=0, fail_idx=0, out_valid 2 cycles after accept, sat_count unchanged.
- Entry 29 = {en,XOR,a=1,b=36,k=0}, var1=5, var36=5 → fail_idx=29, latency 9 cycles. Repeat with var36=6 → out_sat=1.
- Hold out_ready=0 for 5 cycles in DONE → outputs stable, in_ready=0. Assert cfg_we during the hold → cfg_err pulses, table unchanged.
- Assert rst mid-EVAL (cycle 3) → out_valid never rises, in_ready=1 next cycle, all entries disabled (next candidate SAT).
- With SPLIT_EVAL_FAIL_MASK_EN: entries 2, 17, 31 set to fail → mask=0x80020004, fail_idx=2, latency 9 cycles.
